prog_run_ctrl: RTL and testbench
================================

PROG_RUN_CTRL -- requirements
Module: prog_run_ctrl

Interface
REQ-001 SHALL have parameter PRINT_DEPTH, default 8, print-capture FIFO depth (power of 2, >=2).
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port start  in  1  one-cycle request to load and run a program.
REQ-005 SHALL have port num_instr  in  10  words to load, sampled with start.
REQ-006 SHALL have port max_cycles  in  16  run-cycle budget, sampled with start; 0 = unlimited.
REQ-007 SHALL have ports in_valid in 1, in_data in 32, in_ready out 1: instruction-word stream.
REQ-008 SHALL have ports instr_we out 1, instr_feed out 32, instr_write_address out 10, proc_rst out 1: processor load/reset side.
REQ-009 SHALL have ports End_signal in 1, Print in 1, toBePrinted in 32: processor status side.
REQ-010 SHALL have ports out_valid out 1, out_data out 32, out_ready in 1: captured print stream.
REQ-011 SHALL have ports busy, done, timeout, overflow, all out 1.

Function
REQ-012 SHALL implement states IDLE, LOAD, PRST, RUN, DONE.
REQ-013 IDLE or DONE with start=1 SHALL latch num_instr/max_cycles, clear done/timeout/overflow, go to LOAD (PRST if num_instr=0).
REQ-014 start outside IDLE/DONE SHALL be ignored.
REQ-015 in_ready SHALL be 1 only in LOAD; a beat is accepted when in_valid&in_ready.
REQ-016 Each accepted beat SHALL appear next cycle as instr_we=1, instr_feed=in_data, instr_write_address=beat index (0,1,...); instr_we=0 otherwise.
REQ-017 After beat num_instr-1 is accepted, SHALL go to PRST; address counter SHALL not wrap within one load.
REQ-018 PRST SHALL hold proc_rst=1 exactly 2 cycles then enter RUN with proc_rst=0.
REQ-019 proc_rst SHALL be 1 in IDLE, LOAD, PRST, DONE; 0 only in RUN.
REQ-020 RUN SHALL count cycles from 1; End_signal=1 SHALL go to DONE, timeout=0.
REQ-021 If max_cycles!=0 and count reaches max_cycles without End_signal, SHALL go to DONE with timeout=1; End_signal same cycle wins (timeout=0).
REQ-022 Print=1 in RUN SHALL push toBePrinted into FIFO; Print outside RUN ignored.
REQ-023 Push when full SHALL drop the word and set sticky overflow, unless out_ready pops in the same cycle, then the push is accepted.
REQ-024 out_valid SHALL be 1 while FIFO non-empty; out_data = oldest word; pop on out_valid&out_ready; FIFO not cleared by start.
REQ-025 busy SHALL be 1 in LOAD, PRST, RUN; done SHALL be 1 in DONE only.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, proc_rst=1, instr_we=0, instr_feed=0, instr_write_address=0, in_ready=0, FIFO empty, out_valid=0, busy=done=timeout=overflow=0.
REQ-027 Reset mid-LOAD/RUN SHALL abort with no further instr_we pulse; next start restarts at address 0.

Configuration
REQ-028 Macro PROG_RUN_PRINT_FIFO_EN defined: FIFO per REQ-022..024.
REQ-029 Macro undefined: no FIFO storage; out_valid=0, out_data=0, overflow=0, Print ignored.

Structure
REQ-030 Package prog_run_pkg SHALL hold state enum, ADDR_W=10, DATA_W=32, CYC_W=16, PRST_CYCLES=2.
REQ-031 FIFO SHALL be sub-module print_fifo (push/pop/full/empty, PRINT_DEPTH parameter).

Verification
REQ-032 start, num_instr=3, beats 0x11,0x22,0x33 with in_valid gap -> instr_we pulses addr 0,1,2 data 0x11,0x22,0x33, then proc_rst high 2 cycles.
REQ-033 num_instr=0, max_cycles=5, no End_signal -> LOAD skipped, DONE after 5 RUN cycles, timeout=1.
REQ-034 End_signal on cycle 5 with max_cycles=5 -> DONE, timeout=0.
REQ-035 10 Print pulses 0..9, out_ready=0, depth 8 -> out_data 0..7 in order, overflow=1; full+pop+push same cycle -> no drop.
REQ-036 rst_n low mid-LOAD after 2 beats -> all REQ-026 values immediately; new start loads from address 0.

Source files
------------

// File: rtl/prog_run_pkg.sv
// Shared types and sizes for the program load/run controller.
package prog_run_pkg;

    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CYC_W       = 16;
    localparam int unsigned PRST_CYCLES = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPrst,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/print_fifo.sv
// Print-capture FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module print_fifo #(
    parameter int unsigned PRINT_DEPTH = 8,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned AW = $clog2(PRINT_DEPTH);

    logic [DATA_W-1:0] r_mem [PRINT_DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_do_push;
    logic              w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/prog_run_ctrl.sv
// Loads a program into the processor, pulses its reset, then runs it under a cycle budget.
// Print capture is built only when PROG_RUN_PRINT_FIFO_EN is defined.
module prog_run_ctrl
    import prog_run_pkg::*;
#(
    parameter int unsigned PRINT_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_instr,
    input  logic [CYC_W-1:0]  max_cycles,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              instr_we,
    output logic [DATA_W-1:0] instr_feed,
    output logic [ADDR_W-1:0] instr_write_address,
    output logic              proc_rst,
    input  logic              End_signal,
    input  logic              Print,
    input  logic [DATA_W-1:0] toBePrinted,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow
);

    localparam logic [1:0] PRST_LAST = 2'(PRST_CYCLES - 1);

    state_e             r_state;
    logic [ADDR_W-1:0]  r_num;
    logic [ADDR_W-1:0]  r_idx;
    logic [ADDR_W-1:0]  r_addr;
    logic [CYC_W-1:0]   r_max;
    logic [CYC_W-1:0]   r_cyc;
    logic [1:0]         r_prst_cnt;
    logic               r_we;
    logic [DATA_W-1:0]  r_feed;
    logic               r_timeout;
    logic               r_overflow;
    logic               w_start_ok;
    logic               w_push;
    logic               w_drop;

    assign w_start_ok = start && (r_state == StIdle || r_state == StDone);
    assign w_push     = Print && (r_state == StRun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_num      <= '0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_max      <= '0;
            r_cyc      <= '0;
            r_prst_cnt <= '0;
            r_we       <= 1'b0;
            r_feed     <= '0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_num      <= num_instr;
                        r_max      <= max_cycles;
                        r_timeout  <= 1'b0;
                        r_idx      <= '0;
                        r_prst_cnt <= '0;
                        r_state    <= (num_instr == '0) ? StPrst : StLoad;
                    end
                end
                StLoad: begin
                    if (in_valid) begin
                        r_we   <= 1'b1;
                        r_feed <= in_data;
                        r_addr <= r_idx;
                        r_idx  <= r_idx + ADDR_W'(1);
                        if (r_idx == r_num - ADDR_W'(1)) begin
                            r_state <= StPrst;
                        end
                    end
                end
                StPrst: begin
                    if (r_prst_cnt == PRST_LAST) begin
                        r_state <= StRun;
                        r_cyc   <= CYC_W'(1);
                    end else begin
                        r_prst_cnt <= r_prst_cnt + 2'd1;
                    end
                end
                StRun: begin
                    // End_signal beats the budget when both land on the same cycle.
                    if (End_signal) begin
                        r_state <= StDone;
                    end else if (r_max != '0 && r_cyc == r_max) begin
                        r_state   <= StDone;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cyc <= r_cyc + CYC_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign in_ready            = (r_state == StLoad);
    assign proc_rst            = (r_state != StRun);
    assign busy                = (r_state == StLoad) || (r_state == StPrst) || (r_state == StRun);
    assign done                = (r_state == StDone);
    assign timeout             = r_timeout;
    assign overflow            = r_overflow;
    assign instr_we            = r_we;
    assign instr_feed          = r_feed;
    assign instr_write_address = r_addr;

`ifdef PROG_RUN_PRINT_FIFO_EN
    logic w_full;
    logic w_empty;

    print_fifo #(
        .PRINT_DEPTH (PRINT_DEPTH),
        .DATA_W      (DATA_W)
    ) u_print_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (toBePrinted),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_valid = !w_empty;
    assign w_drop    = w_push && w_full && !out_ready;
`else
    logic w_unused_print;

    assign w_unused_print = ^{toBePrinted, out_ready, w_push, PRINT_DEPTH};
    assign out_valid      = 1'b0;
    assign out_data       = '0;
    assign w_drop         = 1'b0;
`endif

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: directed load/run/print/reset scenarios and randomized programs, all
// compared every cycle against a behavioural model; follows PROG_RUN_PRINT_FIFO_EN like the RTL.
module tb_prog_run_ctrl;

    localparam int DEPTH   = 8;
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_PRST = 2;
    localparam int PH_RUN  = 3;
    localparam int PH_DONE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  num_instr = '0;
    logic [15:0] max_cycles = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        instr_we;
    logic [31:0] instr_feed;
    logic [9:0]  instr_write_address;
    logic        proc_rst;
    logic        End_signal = 1'b0;
    logic        Print = 1'b0;
    logic [31:0] toBePrinted = '0;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of what the controller should be showing.
    int          m_phase;
    int          m_n;
    int          m_max;
    int          m_idx;
    int          m_prst;
    int          m_run;
    bit          m_to;
    bit          m_ovf;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_feed;
    logic [31:0] m_q[$];

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    prog_run_ctrl #(
        .PRINT_DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .num_instr           (num_instr),
        .max_cycles          (max_cycles),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .instr_we            (instr_we),
        .instr_feed          (instr_feed),
        .instr_write_address (instr_write_address),
        .proc_rst            (proc_rst),
        .End_signal          (End_signal),
        .Print               (Print),
        .toBePrinted         (toBePrinted),
        .out_valid           (out_valid),
        .out_data            (out_data),
        .out_ready           (out_ready),
        .busy                (busy),
        .done                (done),
        .timeout             (timeout),
        .overflow            (overflow)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_to    = 1'b0;
        m_ovf   = 1'b0;
        m_we    = 1'b0;
        m_idx   = 0;
        m_q.delete();
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
`ifdef PROG_RUN_PRINT_FIFO_EN
        bit pop;
        bit push;
        pop  = (m_q.size() > 0) && out_ready;
        push = (m_phase == PH_RUN) && Print;
`endif
        m_we = 1'b0;
        case (m_phase)
            PH_IDLE, PH_DONE: begin
                if (start) begin
                    m_n     = int'(num_instr);
                    m_max   = int'(max_cycles);
                    m_to    = 1'b0;
                    m_ovf   = 1'b0;
                    m_idx   = 0;
                    m_prst  = 0;
                    m_phase = (m_n == 0) ? PH_PRST : PH_LOAD;
                end
            end
            PH_LOAD: begin
                if (in_valid) begin
                    m_we   = 1'b1;
                    m_addr = m_idx;
                    m_feed = in_data;
                    m_idx++;
                    if (m_idx == m_n) begin
                        m_phase = PH_PRST;
                        m_prst  = 0;
                    end
                end
            end
            PH_PRST: begin
                m_prst++;
                if (m_prst == 2) begin
                    m_phase = PH_RUN;
                    m_run   = 1;
                end
            end
            PH_RUN: begin
                if (End_signal) begin
                    m_phase = PH_DONE;
                end else if (m_max != 0 && m_run == m_max) begin
                    m_phase = PH_DONE;
                    m_to    = 1'b1;
                end else begin
                    m_run++;
                end
            end
            default: ;
        endcase
`ifdef PROG_RUN_PRINT_FIFO_EN
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(toBePrinted);
            else m_ovf = 1'b1;
        end
`endif
    endtask

    task automatic check_all();
        chk1("in_ready", in_ready, m_phase == PH_LOAD);
        chk1("busy", busy, m_phase inside {PH_LOAD, PH_PRST, PH_RUN});
        chk1("done", done, m_phase == PH_DONE);
        chk1("proc_rst", proc_rst, m_phase != PH_RUN);
        chk1("timeout", timeout, m_to);
        chk1("instr_we", instr_we, m_we);
        if (m_we) begin
            chk32("instr_addr", 32'(instr_write_address), m_addr);
            chk32("instr_feed", instr_feed, m_feed);
        end
        chk1("overflow", overflow, m_ovf);
        chk1("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk32("out_data", out_data, m_q[0]);
`ifndef PROG_RUN_PRINT_FIFO_EN
        chk32("out_data_off", out_data, 32'h0);
`endif
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        start      = 1'b0;
        in_valid   = 1'b0;
        End_signal = 1'b0;
        Print      = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_proc_rst"}, proc_rst, 1'b1);
        chk1({tag, "_instr_we"}, instr_we, 1'b0);
        chk32({tag, "_instr_feed"}, instr_feed, 32'h0);
        chk32({tag, "_instr_addr"}, 32'(instr_write_address), 32'h0);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_out_valid"}, out_valid, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_timeout"}, timeout, 1'b0);
        chk1({tag, "_overflow"}, overflow, 1'b0);
    endtask

    // Runs until done, counting RUN cycles; End_signal is raised on RUN cycle end_at (0 = never).
    task automatic run_until_done(input int end_at, input int budget, output int runc);
        runc = 0;
        for (int c = 0; c < budget && done !== 1'b1; c++) begin
            End_signal = 1'b0;
            if (proc_rst === 1'b0) begin
                runc++;
                End_signal = (runc == end_at);
            end
            tick();
        end
        End_signal = 1'b0;
        chk1("done_reached", done, 1'b1);
    endtask

    initial begin
        int runc;
        int plen;

        model_reset();
        #1 rst_n = 1'b0;
        #1 chk_reset("por");
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        tick();
        tick();

        // Three-word load with a gap in in_valid.
        num_instr = 10'd3; max_cycles = 16'd0; start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; tick();
        in_valid = 1'b0; tick();
        in_valid = 1'b1; in_data = 32'h22; tick();
        in_data = 32'h33; tick();
        in_valid = 1'b0;
        plen = 0;
        while (proc_rst === 1'b1 && busy === 1'b1 && plen < 10) begin
            plen++;
            tick();
        end
        chk32("prst_len", plen, 2);
        run_until_done(3, 50, runc);
        chk32("run_len_end3", runc, 3);
        chk1("timeout_end3", timeout, 1'b0);

        // Empty program, budget expires.
        num_instr = 10'd0; max_cycles = 16'd5; start = 1'b1; tick(); start = 1'b0;
        run_until_done(0, 50, runc);
        chk32("run_len_budget", runc, 5);
        chk1("timeout_budget", timeout, 1'b1);

        // End_signal on the last budget cycle wins.
        start = 1'b1; tick(); start = 1'b0;
        chk1("timeout_cleared", timeout, 1'b0);
        run_until_done(5, 50, runc);
        chk32("run_len_tie", runc, 5);
        chk1("timeout_tie", timeout, 1'b0);

        // Ten prints into an eight-deep FIFO with no consumer.
        num_instr = 10'd0; max_cycles = 16'd0; start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            Print = 1'b1; toBePrinted = 32'(i); tick();
        end
        Print = 1'b0; End_signal = 1'b1; tick(); End_signal = 1'b0;
`ifdef PROG_RUN_PRINT_FIFO_EN
        chk1("ovf_after_10", overflow, 1'b1);
        chk32("head_is_0", out_data, 32'h0);
`else
        chk1("ovf_off", overflow, 1'b0);
        chk1("valid_off", out_valid, 1'b0);
`endif
        // Full FIFO: push with a simultaneous pop must not drop.
        start = 1'b1; tick(); start = 1'b0;
        chk1("ovf_cleared", overflow, 1'b0);
        tick(); tick();
        Print = 1'b1; toBePrinted = 32'hAA; out_ready = 1'b1; tick();
        Print = 1'b0; out_ready = 1'b0; End_signal = 1'b1; tick(); End_signal = 1'b0;
        chk1("ovf_full_pop_push", overflow, 1'b0);
`ifdef PROG_RUN_PRINT_FIFO_EN
        for (int i = 0; i < 8; i++) begin
            chk32("drain_data", out_data, (i < 7) ? 32'(i + 1) : 32'hAA);
            out_ready = 1'b1; tick();
        end
        out_ready = 1'b0;
        chk1("drain_empty", out_valid, 1'b0);
`endif

        // Reset in the middle of a load, then reload from address 0.
        num_instr = 10'd4; start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'hB1; tick();
        in_data = 32'hB2; tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_load");
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        tick();
        num_instr = 10'd2; start = 1'b1; tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'hC1; tick();
        in_data = 32'hC2; tick();
        in_valid = 1'b0;
        run_until_done(1, 50, runc);
        chk32("run_len_after_rst", runc, 1);

        // Randomized programs with spurious starts and changing inputs while busy.
        for (int p = 0; p < 25; p++) begin
            int n;
            int mx;
            n  = $urandom_range(0, 6);
            mx = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
            num_instr = 10'(n); max_cycles = 16'(mx);
            out_ready = 1'($urandom_range(0, 1));
            start = 1'b1; tick(); start = 1'b0;
            for (int c = 0; c < 400 && done !== 1'b1; c++) begin
                in_valid    = 1'($urandom_range(0, 1));
                in_data     = $urandom;
                End_signal  = ($urandom_range(0, 7) == 0);
                Print       = ($urandom_range(0, 2) == 0);
                toBePrinted = $urandom;
                out_ready   = 1'($urandom_range(0, 1));
                start       = ($urandom_range(0, 9) == 0);
                num_instr   = 10'($urandom_range(0, 1023));
                max_cycles  = 16'($urandom_range(0, 65535));
                tick();
            end
            idle();
            chk1("rand_done", done, 1'b1);
            repeat ($urandom_range(0, 3)) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end

        out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        chk1("final_empty", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
